// File: rtl/cmp_pkg.sv
// Shared types and constants for the commit scoreboard: retire record layout,
// mismatch cause bit positions, watchdog limit and the compare FSM states.
package cmp_pkg;

    localparam int XLEN_DEF = 32;
    localparam int RA_W_DEF = 3;

    // Default-width retire record; the top rebuilds it with its own widths.
    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic                we;
        logic [RA_W_DEF-1:0] rd;
        logic [XLEN_DEF-1:0] data;
    } retire_rec_t;

    // Bit positions inside mm_cause ({pc, we, rd, data}).
    localparam int CAUSE_PC   = 3;
    localparam int CAUSE_WE   = 2;
    localparam int CAUSE_RD   = 1;
    localparam int CAUSE_DATA = 0;

    // Cycles an unpaired record may wait before being flagged.
    localparam int TIMEOUT_CYC = 4095;

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } cmp_state_e;

endpackage

// File: rtl/cmp_fifo.sv
// DEPTH-entry queue of retire records with push/pop, full/empty flags and a
// combinational head output. Pointers carry one extra wrap bit so full and
// empty are told apart by comparing the MSBs.
module cmp_fifo
    import cmp_pkg::*;
#(
    parameter type T     = retire_rec_t,
    parameter int  DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     wdata,
    input  logic pop,
    output T     head,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    T            mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; reset drops every stored entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage array, written on accepted pushes only.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/commit_scoreboard.sv
// In-order retire checker: queues DUT and reference retire records on two
// independent channels, pops both heads together and reports field-level
// mismatches. Optional feature macro CMP_TIMEOUT_EN adds a watchdog that
// flags a record left unpaired for TIMEOUT_CYC cycles.
module commit_scoreboard
    import cmp_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int RA_W        = 3,
    parameter int DEPTH       = 8,
    parameter int CNT_W       = 16,
    parameter int STOP_ON_ERR = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dut_valid,
    output logic             dut_ready,
    input  logic [XLEN-1:0]  dut_pc,
    input  logic             dut_we,
    input  logic [RA_W-1:0]  dut_rd,
    input  logic [XLEN-1:0]  dut_data,
    input  logic             ref_valid,
    output logic             ref_ready,
    input  logic [XLEN-1:0]  ref_pc,
    input  logic             ref_we,
    input  logic [RA_W-1:0]  ref_rd,
    input  logic [XLEN-1:0]  ref_data,
    input  logic             clear,
    output logic             mismatch,
    output logic [3:0]       mm_cause,
    output logic [XLEN-1:0]  mm_pc,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             halted,
    output logic             idle
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            we;
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] data;
    } rec_t;

    // Handshake: a record is taken on a clk edge where x_valid && x_ready;
    // x_ready only depends on queue fullness and the FSM, never on x_valid.
    cmp_state_e       state_q, state_d;
    rec_t             dut_wr, ref_wr, dut_head, ref_head;
    logic             dut_full, dut_empty, ref_full, ref_empty;
    logic             run, pop;
    logic [3:0]       cause_c;
    logic             to_fire;
    logic [XLEN-1:0]  to_pc;
    logic             err_ev, good_ev;
    logic [3:0]       ev_cause;
    logic [XLEN-1:0]  ev_pc;

    logic             mismatch_q;
    logic [3:0]       mm_cause_q;
    logic [XLEN-1:0]  mm_pc_q;
    logic [CNT_W-1:0] match_cnt_q, err_cnt_q;

    assign dut_wr = '{pc: dut_pc, we: dut_we, rd: dut_rd, data: dut_data};
    assign ref_wr = '{pc: ref_pc, we: ref_we, rd: ref_rd, data: ref_data};

    assign run       = (state_q == ST_RUN);
    assign dut_ready = !dut_full && run;
    assign ref_ready = !ref_full && run;
    assign pop       = run && !dut_empty && !ref_empty;

    cmp_fifo #(.T(rec_t), .DEPTH(DEPTH)) u_dut_q (
        .clk(clk), .rst(rst), .push(dut_valid && dut_ready), .wdata(dut_wr),
        .pop(pop), .head(dut_head), .full(dut_full), .empty(dut_empty)
    );

    cmp_fifo #(.T(rec_t), .DEPTH(DEPTH)) u_ref_q (
        .clk(clk), .rst(rst), .push(ref_valid && ref_ready), .wdata(ref_wr),
        .pop(pop), .head(ref_head), .full(ref_full), .empty(ref_empty)
    );

    // Field compare of the two heads; rd/data only matter when both write.
    always_comb begin
        cause_c             = '0;
        cause_c[CAUSE_PC]   = (dut_head.pc != ref_head.pc);
        cause_c[CAUSE_WE]   = (dut_head.we != ref_head.we);
        cause_c[CAUSE_RD]   = dut_head.we && ref_head.we && (dut_head.rd != ref_head.rd);
        cause_c[CAUSE_DATA] = dut_head.we && ref_head.we && (dut_head.data != ref_head.data);
    end

`ifdef CMP_TIMEOUT_EN
    localparam logic [11:0] WD_LAST = 12'(TIMEOUT_CYC - 1);
    logic [11:0] wd_q, wd_d;

    // Watchdog: counts RUN cycles with exactly one queue holding records.
    always_comb begin
        wd_d    = wd_q;
        to_fire = 1'b0;
        to_pc   = !dut_empty ? dut_head.pc : ref_head.pc;
        if (!run || !(dut_empty ^ ref_empty)) begin
            wd_d = '0;
        end else if (wd_q == WD_LAST) begin
            to_fire = 1'b1;
            wd_d    = '0;
        end else begin
            wd_d = wd_q + 12'd1;
        end
    end

    // Watchdog register.
    always_ff @(posedge clk) begin
        if (rst) wd_q <= '0;
        else     wd_q <= wd_d;
    end
`else
    assign to_fire = 1'b0;
    assign to_pc   = '0;
`endif

    assign err_ev   = (pop && (cause_c != 4'b0000)) || to_fire;
    assign good_ev  = pop && (cause_c == 4'b0000);
    assign ev_cause = to_fire ? 4'b1111 : cause_c;
    assign ev_pc    = to_fire ? to_pc : dut_head.pc;

    // FSM next state: halt on an error when configured, leave on clear.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (err_ev && (STOP_ON_ERR != 0)) state_d = ST_HALTED;
            ST_HALTED: if (clear) state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    // Registered compare results and saturating counters; clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch_q  <= 1'b0;
            mm_cause_q  <= '0;
            mm_pc_q     <= '0;
            match_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            mismatch_q <= err_ev;
            if (err_ev) begin
                mm_cause_q <= ev_cause;
                mm_pc_q    <= ev_pc;
            end
            if (clear) begin
                match_cnt_q <= '0;
                err_cnt_q   <= '0;
            end else begin
                if (good_ev && (match_cnt_q != '1))
                    match_cnt_q <= match_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (err_ev && (err_cnt_q != '1))
                    err_cnt_q <= err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign mismatch  = mismatch_q;
    assign mm_cause  = mm_cause_q;
    assign mm_pc     = mm_pc_q;
    assign match_cnt = match_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign halted    = (state_q == ST_HALTED);
    assign idle      = dut_empty && ref_empty;

endmodule

// File: tb/tb_commit_scoreboard.sv
// Testbench for commit_scoreboard: default instance (DEPTH=8, CNT_W=16,
// STOP_ON_ERR=1) plus a small saturation instance (CNT_W=4, STOP_ON_ERR=0).
// The watchdog step runs only when CMP_TIMEOUT_EN is defined.
module tb_commit_scoreboard;

    localparam int W = 36;  // {cause[3:0], pc[31:0]}

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        dut_valid = 1'b0, ref_valid = 1'b0, clear = 1'b0;
    logic [31:0] dut_pc = '0, ref_pc = '0, dut_data = '0, ref_data = '0;
    logic        dut_we = 1'b0, ref_we = 1'b0;
    logic [2:0]  dut_rd = '0, ref_rd = '0;
    logic        dut_ready, ref_ready, mismatch, halted, idle;
    logic [3:0]  mm_cause;
    logic [31:0] mm_pc;
    logic [15:0] match_cnt, err_cnt;

    logic        s_dut_valid = 1'b0, s_ref_valid = 1'b0, s_clear = 1'b0;
    logic [31:0] s_dut_pc = '0, s_ref_pc = '0;
    logic        s_dut_ready, s_ref_ready, s_mismatch, s_halted, s_idle;
    logic [3:0]  s_mm_cause, s_match_cnt, s_err_cnt;
    logic [31:0] s_mm_pc;

    logic [W-1:0] exp_q[$];
    logic [15:0]  prev_match = '0;
    int           pass_cnt = 0;
    int           fail_cnt = 0;

    commit_scoreboard u_dut (
        .clk(clk), .rst(rst),
        .dut_valid(dut_valid), .dut_ready(dut_ready), .dut_pc(dut_pc),
        .dut_we(dut_we), .dut_rd(dut_rd), .dut_data(dut_data),
        .ref_valid(ref_valid), .ref_ready(ref_ready), .ref_pc(ref_pc),
        .ref_we(ref_we), .ref_rd(ref_rd), .ref_data(ref_data),
        .clear(clear), .mismatch(mismatch), .mm_cause(mm_cause), .mm_pc(mm_pc),
        .match_cnt(match_cnt), .err_cnt(err_cnt), .halted(halted), .idle(idle)
    );

    commit_scoreboard #(.CNT_W(4), .STOP_ON_ERR(0)) u_sat (
        .clk(clk), .rst(rst),
        .dut_valid(s_dut_valid), .dut_ready(s_dut_ready), .dut_pc(s_dut_pc),
        .dut_we(1'b1), .dut_rd(3'd1), .dut_data(32'd7),
        .ref_valid(s_ref_valid), .ref_ready(s_ref_ready), .ref_pc(s_ref_pc),
        .ref_we(1'b1), .ref_rd(3'd1), .ref_data(32'd7),
        .clear(s_clear), .mismatch(s_mismatch), .mm_cause(s_mm_cause), .mm_pc(s_mm_pc),
        .match_cnt(s_match_cnt), .err_cnt(s_err_cnt), .halted(s_halted), .idle(s_idle)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference compare model.
    function automatic logic [3:0] model_cause(
        input logic [31:0] dpc, input logic dwe, input logic [2:0] drd, input logic [31:0] dd,
        input logic [31:0] rpc, input logic rwe, input logic [2:0] rrd, input logic [31:0] rdd);
        logic [3:0] c;
        c[3] = (dpc != rpc);
        c[2] = (dwe != rwe);
        c[1] = dwe && rwe && (drd != rrd);
        c[0] = dwe && rwe && (dd != rdd);
        return c;
    endfunction

    // Drivers
    task automatic push_dut(input logic [31:0] pc, input logic we, input logic [2:0] rd,
                            input logic [31:0] data);
        int c = 0;
        @(negedge clk);
        dut_pc = pc; dut_we = we; dut_rd = rd; dut_data = data; dut_valid = 1'b1;
        while (!dut_ready && c < 200) begin @(negedge clk); c++; end
        if (!dut_ready) check("push_dut_ready", {63'd0, dut_ready}, 64'd1);
        @(posedge clk); #1;
        dut_valid = 1'b0;
    endtask

    task automatic push_ref(input logic [31:0] pc, input logic we, input logic [2:0] rd,
                            input logic [31:0] data);
        int c = 0;
        @(negedge clk);
        ref_pc = pc; ref_we = we; ref_rd = rd; ref_data = data; ref_valid = 1'b1;
        while (!ref_ready && c < 200) begin @(negedge clk); c++; end
        if (!ref_ready) check("push_ref_ready", {63'd0, ref_ready}, 64'd1);
        @(posedge clk); #1;
        ref_valid = 1'b0;
    endtask

    task automatic send_pair(
        input logic [31:0] dpc, input logic dwe, input logic [2:0] drd, input logic [31:0] dd,
        input logic [31:0] rpc, input logic rwe, input logic [2:0] rrd, input logic [31:0] rdd);
        exp_q.push_back({model_cause(dpc, dwe, drd, dd, rpc, rwe, rrd, rdd), dpc});
        push_dut(dpc, dwe, drd, dd);
        push_ref(rpc, rwe, rrd, rdd);
    endtask

    task automatic wait_drain(input string tag);
        int c = 0;
        while (!(idle && exp_q.size() == 0) && c < 300) begin @(negedge clk); c++; end
        repeat (2) @(negedge clk);
        check(tag, {63'd0, idle}, 64'd1);
    endtask

    task automatic pulse_clear();
        @(negedge clk); clear = 1'b1;
        @(posedge clk); #1; clear = 1'b0;
        @(negedge clk);
    endtask

    // Scoreboard: every result event of the main instance pops one entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (mismatch) begin
                if (exp_q.size() == 0) check("unexpected_mismatch", {28'd0, mm_cause, mm_pc}, 64'd0);
                else check("mismatch_result", {28'd0, mm_cause, mm_pc}, {28'd0, exp_q.pop_front()});
            end else if (match_cnt == prev_match + 16'd1) begin
                if (exp_q.size() == 0) check("unexpected_match", {48'd0, match_cnt}, {48'd0, prev_match});
                else check("match_result", 64'd0, {60'd0, exp_q.pop_front()[W-1:W-4]});
            end
        end
        prev_match <= match_cnt;
    end

    initial begin
        int c;
        // Reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mismatch",  {63'd0, mismatch}, 64'd0);
        check("rst_mm_cause",  {60'd0, mm_cause}, 64'd0);
        check("rst_mm_pc",     {32'd0, mm_pc}, 64'd0);
        check("rst_match_cnt", {48'd0, match_cnt}, 64'd0);
        check("rst_err_cnt",   {48'd0, err_cnt}, 64'd0);
        check("rst_halted",    {63'd0, halted}, 64'd0);
        check("rst_idle",      {63'd0, idle}, 64'd1);
        check("rst_ready",     {62'd0, dut_ready, ref_ready}, 64'd3);

        // Matched stream of 20 records
        for (int i = 0; i < 20; i++)
            send_pair(32'h100 + 32'(4 * i), 1'b1, 3'(i % 8), 32'(i),
                      32'h100 + 32'(4 * i), 1'b1, 3'(i % 8), 32'(i));
        wait_drain("match_idle");
        check("match_cnt20", {48'd0, match_cnt}, 64'd20);
        check("match_err0",  {48'd0, err_cnt}, 64'd0);

        // Data error on record 3 halts the checker
        for (int i = 0; i < 3; i++)
            send_pair(32'h100 + 32'(4 * i), 1'b1, 3'(i), 32'(i),
                      32'h100 + 32'(4 * i), 1'b1, 3'(i), 32'(i));
        send_pair(32'h10C, 1'b1, 3'd3, 32'd6, 32'h10C, 1'b1, 3'd3, 32'd5);
        c = 0;
        while (!halted && c < 20) begin @(negedge clk); c++; end
        @(negedge clk);
        check("err_halted",   {63'd0, halted}, 64'd1);
        check("err_ready",    {62'd0, dut_ready, ref_ready}, 64'd0);
        check("err_pulse_end", {63'd0, mismatch}, 64'd0);
        check("err_err_cnt",  {48'd0, err_cnt}, 64'd1);
        check("err_match_cnt", {48'd0, match_cnt}, 64'd23);
        check("err_sb_empty", {32'd0, 32'(exp_q.size())}, 64'd0);
        pulse_clear();
        check("clr_halted",   {63'd0, halted}, 64'd0);
        check("clr_counters", {32'd0, match_cnt, err_cnt}, 64'd0);
        check("clr_ready",    {62'd0, dut_ready, ref_ready}, 64'd3);

        // we=0 masks rd/data differences
        for (int i = 0; i < 3; i++)
            send_pair(32'h300 + 32'(4 * i), 1'b0, 3'd1, 32'hAA,
                      32'h300 + 32'(4 * i), 1'b0, 3'd2, 32'h55);
        wait_drain("mask_idle");
        check("mask_match", {48'd0, match_cnt}, 64'd3);
        check("mask_err",   {48'd0, err_cnt}, 64'd0);

        // Backpressure: fill the DUT queue with the ref side silent
        pulse_clear();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({4'd0, 32'h400 + 32'(4 * i)});
            push_dut(32'h400 + 32'(4 * i), 1'b1, 3'(i), 32'(i * 3));
        end
        @(negedge clk);
        check("bp_dut_ready", {63'd0, dut_ready}, 64'd0);
        check("bp_ref_ready", {63'd0, ref_ready}, 64'd1);
        check("bp_idle",      {63'd0, idle}, 64'd0);
        for (int i = 0; i < 8; i++)
            push_ref(32'h400 + 32'(4 * i), 1'b1, 3'(i), 32'(i * 3));
        wait_drain("bp_drain");
        check("bp_match", {48'd0, match_cnt}, 64'd8);

        // Reset mid-operation discards queued records
        push_dut(32'h500, 1'b1, 3'd0, 32'd1);
        push_dut(32'h504, 1'b1, 3'd0, 32'd2);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check("mid_rst_idle",  {63'd0, idle}, 64'd1);
        check("mid_rst_cnt",   {32'd0, match_cnt, err_cnt}, 64'd0);
        check("mid_rst_pulse", {63'd0, mismatch}, 64'd0);

        // Saturation on the CNT_W=4, STOP_ON_ERR=0 instance
        @(negedge clk);
        s_dut_valid = 1'b1; s_ref_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_dut_pc = 32'(i); s_ref_pc = 32'(i + 1);
            @(posedge clk); #1;
        end
        s_dut_valid = 1'b0; s_ref_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("sat_err_cnt",   {60'd0, s_err_cnt}, 64'd15);
        check("sat_match_cnt", {60'd0, s_match_cnt}, 64'd0);
        check("sat_not_halted", {63'd0, s_halted}, 64'd0);
        check("sat_idle",      {63'd0, s_idle}, 64'd1);

`ifdef CMP_TIMEOUT_EN
        // Watchdog on an unpaired DUT record
        exp_q.push_back({4'hF, 32'h200});
        push_dut(32'h200, 1'b1, 3'd2, 32'd9);
        c = 0;
        while (exp_q.size() != 0 && c < 4400) begin @(negedge clk); c++; end
        check("to_fired",   {32'd0, 32'(exp_q.size())}, 64'd0);
        @(negedge clk);
        check("to_halted",  {63'd0, halted}, 64'd1);
        check("to_err_cnt", {48'd0, err_cnt}, 64'd1);
`endif

        check("final_sb_empty", {32'd0, 32'(exp_q.size())}, 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
        $finish;
    end

endmodule

// File: doc/commit_scoreboard.md
Name: commit_scoreboard

Overview:
- Synthesizable in-order retire checker for the kaf27 CPU testbench; replaces per-instruction DPI checkreg/checkmemory calls with a buffered, parametrised compare.
- Accepts DUT retire records on one channel and reference-model retire records on a second channel, each with its own valid/ready handshake.
- Queues each channel independently and compares heads pairwise.
- Reports mismatches with field-level cause; optional halt-on-first-error mode.

Parameters:
- XLEN, 32, data/PC width
- RA_W, 3, register address width
- DEPTH, 8, entries per channel queue (power of 2, >=2)
- CNT_W, 16, width of match/error counters
- STOP_ON_ERR, 1, 1 = halt comparison after first mismatch until clear

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- dut_valid  in  1  DUT retire record valid
- dut_ready  out  1  DUT queue can accept
- dut_pc  in  XLEN  retired PC
- dut_we  in  1  retire wrote a register
- dut_rd  in  RA_W  destination register
- dut_data  in  XLEN  write-back value
- ref_valid/ref_ready/ref_pc/ref_we/ref_rd/ref_data: same as dut_*, model side
- clear  in  1  leave HALTED, zero counters
- mismatch  out  1  one-cycle pulse on compare failure
- mm_cause  out  4  {pc, we, rd, data} differ bits, held until next mismatch
- mm_pc  out  XLEN  DUT PC of last mismatch
- match_cnt  out  CNT_W  saturating count of good compares
- err_cnt  out  CNT_W  saturating count of mismatches
- halted  out  1  FSM in HALTED
- idle  out  1  both queues empty

Behaviour:
- Reset: queues empty, FSM=RUN; dut_ready=ref_ready=1; mismatch=0, mm_cause=0, mm_pc=0, match_cnt=0, err_cnt=0, halted=0, idle=1.
- Push: an entry is written when x_valid && x_ready on the clk edge. x_ready = !full_x && !halted.
- Full: x_ready=0 while a queue holds DEPTH entries. A push and a pop in the same cycle on a full queue is not possible because ready is 0. On a non-full queue, simultaneous push and pop keep the count unchanged.
- Compare: in RUN with both heads valid, pop both heads in the same cycle and compare combinationally.
  - pc is always compared, as is we.
  - rd and data are compared only when both we=1.
  - Results are registered: mismatch, mm_cause and counters update 1 cycle after the pop.
  - Latency: a record pushed into an empty queue whose partner is already waiting is popped the next cycle, and its result is visible the cycle after that.
- FSM states:
  - RUN -> HALTED on a mismatch when STOP_ON_ERR=1. The failing pair is still popped.
  - HALTED: no pops, no pushes (ready=0), counters frozen.
  - HALTED -> RUN on clear. Queue contents are retained.
  - With STOP_ON_ERR=0 the FSM stays in RUN.
- clear in RUN zeroes match_cnt and err_cnt only. If a compare result lands in the same cycle, clear takes priority and the counters end at 0.
- Counters saturate at 2^CNT_W-1 with no wrap.
- Pointers are log2(DEPTH)+1 bits. Full/empty is decided by the MSB compare. Pointers wrap naturally.
- Reset mid-operation discards all queued entries and any pending result. No mismatch pulse is emitted.
- idle is combinational from the queue empty flags.

Optional Feature:
- Macro: CMP_TIMEOUT_EN.
- When defined:
  - A 12-bit watchdog counts cycles in RUN while exactly one queue is non-empty.
  - It resets whenever a pop occurs or both queues are empty.
  - On reaching 4095 it raises the mismatch pulse with mm_cause=4'b1111, captures the head PC of the non-empty queue (DUT preferred) into mm_pc, and increments err_cnt.
  - It follows the STOP_ON_ERR rule.
- When undefined: no watchdog logic; an unpaired record waits indefinitely.

Decomposition:
- Shared package cmp_pkg:
  - retire_rec_t packed struct {pc, we, rd, data}
  - cause bit index constants CAUSE_PC=3, CAUSE_WE=2, CAUSE_RD=1, CAUSE_DATA=0
  - TIMEOUT_CYC=4095
  - FSM enum {ST_RUN, ST_HALTED}
- One sub-module: cmp_fifo, a parametrised DEPTH x retire_rec_t queue with push/pop/full/empty and head output, instantiated twice.

Test Plan:
- Matched stream: 20 identical records (pc=0x100+4i, we=1, rd=i%8, data=i) on both sides -> match_cnt=20, err_cnt=0, mismatch never asserted, idle=1 at end.
- Data error: record 3 has ref_data=5 vs dut_data=6, STOP_ON_ERR=1 -> mismatch pulse, mm_cause=4'b0001, mm_pc=0x10C, halted=1, both ready=0. clear -> halted=0, counters=0.
- we=0 masking: dut_we=ref_we=0, rd/data differ -> counted as match, no mismatch.
- Backpressure: 8 DUT pushes with ref silent (DEPTH=8) -> dut_ready=0 after the 8th. Then 8 ref pushes -> all pop, match_cnt=8.
- Saturation, CNT_W=4, STOP_ON_ERR=0: 20 mismatching pairs -> err_cnt=15 held.
- CMP_TIMEOUT_EN: single DUT record at pc=0x200, ref idle -> mismatch after 4095 cycles, mm_cause=4'b1111, mm_pc=0x200.
